// File: rtl/acc_exec_ctrl.sv
// Instruction sequencer for the 2-bit-control accumulator ALU.
// It accepts an instruction, stages the operands to the ALU, captures the result and commits it to ACC or PC.
module acc_exec_ctrl #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    parameter int PC_W    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [7:0]                 instr,
    input  logic                       rf_we,
    input  logic [$clog2(REG_CNT)-1:0] rf_waddr,
    input  logic [DATA_W-1:0]          rf_wdata,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [1:0]                 alu_ctrl,
    input  logic [DATA_W-1:0]          alu_result,
    output logic [DATA_W-1:0]          acc,
    output logic [PC_W-1:0]            pc,
    output logic                       done,
    output logic                       branch_taken
);

    localparam int IDX_W = $clog2(REG_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_NAND = 2'b01,
        OP_BNZ  = 2'b10,
        OP_SLT  = 2'b11
    } op_e;

    state_e              state;
    state_e              next_state;
    logic                accept;
    op_e                 op_q;
    logic [DATA_W-1:0]   res_q;
    logic [DATA_W-1:0]   rf [REG_CNT];
    logic [IDX_W-1:0]    rs;
    logic [1:0]          op_in;
    logic [DATA_W-1:0]   rs_data;
    logic                unused_instr_bits;

    assign op_in             = instr[7:6];
    assign rs                = instr[3 +: IDX_W];
    assign unused_instr_bits = ^instr[2:0];

    // A write landing on the same edge as the accept must be seen by the operand.
    assign rs_data = (rf_we && (rf_waddr == rs)) ? rf_wdata : rf[rs];

    assign instr_ready = (state == IDLE);

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults are assigned first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the register file is cleared on reset because every entry must read 0 afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Operand stage: held unchanged from accept until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= 2'b00;
            op_q     <= OP_ADD;
        end else if (accept) begin
            alu_a    <= acc;
            alu_b    <= rs_data;
            alu_ctrl <= op_in;
            op_q     <= op_e'(op_in);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
        end else if (state == EXEC) begin
            res_q <= alu_result;
        end
    end

    // Commit stage: bnz redirects the PC only when the staged accumulator was zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            pc           <= '0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            done <= (state == WB);
            if (state == WB) begin
                if (op_q == OP_BNZ) begin
                    if (alu_a == '0) begin
                        pc           <= res_q[PC_W-1:0];
                        branch_taken <= 1'b1;
                    end else begin
                        pc           <= pc + PC_W'(1);
                        branch_taken <= 1'b0;
                    end
                end else begin
                    acc          <= res_q;
                    pc           <= pc + PC_W'(1);
                    branch_taken <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Bench for acc_exec_ctrl: a behavioural ALU plus an architectural model (acc, pc, register file).
// The bench runs directed steps and then randomized instructions.
module tb_acc_exec_ctrl;

    localparam int DATA_W  = 8;
    localparam int REG_CNT = 8;
    localparam int PC_W    = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [7:0]        instr = 8'h00;
    logic              rf_we = 1'b0;
    logic [2:0]        rf_waddr = 3'd0;
    logic [DATA_W-1:0] rf_wdata = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result, acc;
    logic [1:0]        alu_ctrl;
    logic [PC_W-1:0]   pc;
    logic              done, branch_taken;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_acc;
    logic [4:0] m_pc;
    logic [7:0] m_rf [REG_CNT];

    always #5 clk = ~clk;

    acc_exec_ctrl #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .acc(acc), .pc(pc), .done(done), .branch_taken(branch_taken)
    );

    // Combinational ALU: add, nand, bnz target (when acc == 0), unsigned set-less-than.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = ~(alu_a & alu_b);
            2'b10: alu_result = (alu_a == 0) ? {3'b000, alu_b[4:0]} : 8'h00;
            2'b11: alu_result = (alu_a < alu_b) ? 8'h01 : 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_pc  = 5'd0;
        for (int i = 0; i < REG_CNT; i++) m_rf[i] = 8'h00;
    endtask

    task automatic rf_write(input int addr, input logic [7:0] data);
        rf_we = 1'b1; rf_waddr = 3'(addr); rf_wdata = data;
        @(negedge clk);
        rf_we = 1'b0;
        m_rf[addr] = data;
    endtask

    // One full instruction, entered at a negedge; returns at the negedge after commit.
    task automatic exec(input logic [1:0] op, input int rs, input logic we, input int wa,
                        input logic [7:0] wd, input logic mid_wr);
        logic [7:0] a, b;
        logic       exp_bt;
        int         n = 0;
        while (!instr_ready && n < 10) begin @(negedge clk); n++; end
        if (!instr_ready) begin
            check("ready_wait", 32'(instr_ready), 1);
            return;
        end
        instr_valid = 1'b1;
        instr       = {op, 3'(rs), 3'b000};
        rf_we = we; rf_waddr = 3'(wa); rf_wdata = wd;
        if (we) m_rf[wa] = wd;
        a = m_acc;
        b = m_rf[rs];
        @(negedge clk);
        instr_valid = 1'b0;
        rf_we       = 1'b0;
        instr       = 8'($urandom);
        check("exec_a", alu_a, a);
        check("exec_b", alu_b, b);
        check("exec_ctrl", alu_ctrl, op);
        check("exec_ready", instr_ready, 0);
        if (mid_wr) begin
            rf_we = 1'b1; rf_waddr = 3'(rs); rf_wdata = ~b;
            m_rf[rs] = ~b;
        end
        @(negedge clk);
        rf_we = 1'b0;
        check("wb_done", done, 0);
        check("wb_b_hold", alu_b, b);
        @(negedge clk);
        exp_bt = 1'b0;
        case (op)
            2'b00: begin m_acc = a + b;               m_pc = m_pc + 1; end
            2'b01: begin m_acc = ~(a & b);            m_pc = m_pc + 1; end
            2'b11: begin m_acc = (a < b) ? 8'd1 : 8'd0; m_pc = m_pc + 1; end
            2'b10: begin
                if (a == 0) begin m_pc = b[4:0]; exp_bt = 1'b1; end
                else m_pc = m_pc + 1;
            end
        endcase
        check("commit_done", done, 1);
        check("commit_acc", acc, m_acc);
        check("commit_pc", pc, m_pc);
        check("commit_bt", branch_taken, exp_bt);
    endtask

    // Drives acc to x through two nands: ~(acc & 0) = FF, then ~(FF & ~x) = x.
    task automatic load_acc(input logic [7:0] x);
        rf_write(6, 8'h00);
        rf_write(7, ~x);
        exec(2'b01, 6, 1'b0, 0, 8'h00, 1'b0);
        exec(2'b01, 7, 1'b0, 0, 8'h00, 1'b0);
    endtask

    initial begin
        int accepts, dones;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_acc", acc, 0);
        check("rst_pc", pc, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_ctrl", alu_ctrl, 0);
        check("rst_done", done, 0);
        check("rst_bt", branch_taken, 0);
        reset = 1'b0;
        @(negedge clk);

        // add and wrap
        rf_write(1, 8'h05);
        rf_write(2, 8'h03);
        exec(2'b00, 1, 1'b0, 0, 8'h00, 1'b0);
        check("add1_acc", acc, 8'h05);
        exec(2'b00, 2, 1'b0, 0, 8'h00, 1'b0);
        check("add2_acc", acc, 8'h08);
        check("add2_pc", pc, 2);
        load_acc(8'hFF);
        rf_write(3, 8'h02);
        exec(2'b00, 3, 1'b0, 0, 8'h00, 1'b0);
        check("add_wrap", acc, 8'h01);

        // nand
        load_acc(8'hF0);
        rf_write(3, 8'h3C);
        exec(2'b01, 3, 1'b0, 0, 8'h00, 1'b0);
        check("nand_acc", acc, 8'hCF);
        check("nand_bt", branch_taken, 0);

        // slt, with single-cycle done
        load_acc(8'h02);
        rf_write(4, 8'h07);
        exec(2'b11, 4, 1'b0, 0, 8'h00, 1'b0);
        check("slt_lt", acc, 8'h01);
        @(negedge clk);
        check("done_width", done, 0);
        load_acc(8'h07);
        exec(2'b11, 4, 1'b0, 0, 8'h00, 1'b0);
        check("slt_eq", acc, 8'h00);

        // bnz taken / not taken, pc wrap
        load_acc(8'h00);
        rf_write(5, 8'h13);
        exec(2'b10, 5, 1'b0, 0, 8'h00, 1'b0);
        check("bnz_pc", pc, 5'h13);
        check("bnz_taken", branch_taken, 1);
        check("bnz_acc", acc, 8'h00);
        load_acc(8'h04);
        exec(2'b10, 5, 1'b0, 0, 8'h00, 1'b0);
        check("bnz_nt", branch_taken, 0);
        load_acc(8'h00);
        rf_write(5, 8'h1F);
        exec(2'b10, 5, 1'b0, 0, 8'h00, 1'b0);
        check("pc_31", pc, 31);
        exec(2'b00, 0, 1'b0, 0, 8'h00, 1'b0);
        check("pc_wrap", pc, 0);

        // same-edge write forward, and write during EXEC ignored by in-flight op
        load_acc(8'h00);
        exec(2'b00, 1, 1'b1, 1, 8'h22, 1'b0);
        check("fwd_acc", acc, 8'h22);
        exec(2'b00, 1, 1'b0, 0, 8'h00, 1'b1);
        check("midwr_acc", acc, 8'h44);

        // valid held high: one accept per three cycles
        instr_valid = 1'b1;
        instr = {2'b00, 3'd2, 3'b000};
        accepts = 0;
        dones   = 0;
        for (int k = 0; k < 9; k++) begin
            if (instr_valid && instr_ready) accepts++;
            @(negedge clk);
            if (done) dones++;
        end
        instr_valid = 1'b0;
        repeat (3) begin m_acc = m_acc + m_rf[2]; m_pc = m_pc + 1; end
        check("held_accepts", accepts, 3);
        check("held_dones", dones, 3);
        check("held_acc", acc, m_acc);
        check("held_pc", pc, m_pc);

        // reset during EXEC
        instr_valid = 1'b1;
        instr = {2'b00, 3'd1, 3'b000};
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rstx_acc", acc, 0);
        check("rstx_pc", pc, 0);
        @(negedge clk);
        check("rstx_done", done, 0);
        reset = 1'b0;
        #1;
        check("rstx_ready", instr_ready, 1);
        check("rstx_a", alu_a, 0);
        model_reset();
        @(negedge clk);
        check("rstx_nodone", done, 0);

        // randomized instructions against the model
        for (int i = 0; i < 60; i++) begin
            int rs_r, wa_r;
            rs_r = int'($urandom_range(0, 7));
            wa_r = ($urandom_range(0, 2) == 0) ? rs_r : int'($urandom_range(0, 7));
            exec(2'($urandom_range(0, 3)), rs_r, 1'($urandom_range(0, 1)), wa_r,
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
